// File: rtl/memory_arbiter.sv
// Round-robin arbiter serialising per-CPU icache/dcache requests onto one RAM port.
// Define MEMORY_ARBITER_STATS_EN to add per-CPU completed-transfer counters (stat_xfers).
package memory_arbiter_pkg;
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;
endpackage

module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int CPUS = 1
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic [CPUS-1:0]      iREN,
    input  logic [CPUS*32-1:0]   iaddr,
    input  logic [CPUS-1:0]      dREN,
    input  logic [CPUS-1:0]      dWEN,
    input  logic [CPUS*32-1:0]   daddr,
    input  logic [CPUS*32-1:0]   dstore,
    input  logic [CPUS-1:0]      ccwrite,
    input  logic [CPUS-1:0]      cctrans,
    output logic [CPUS-1:0]      iwait,
    output logic [CPUS-1:0]      dwait,
    output logic [CPUS*32-1:0]   iload,
    output logic [CPUS*32-1:0]   dload,
    output logic                 ramREN,
    output logic                 ramWEN,
    output logic [31:0]          ramaddr,
    output logic [31:0]          ramstore,
    input  logic [31:0]          ramload,
    input  ramstate_t            ramstate,
`ifdef MEMORY_ARBITER_STATS_EN
    output logic [CPUS*32-1:0]   stat_xfers,
`endif
    output logic [CPUS-1:0]      ccwait,
    output logic [CPUS-1:0]      ccinv,
    output logic [CPUS*32-1:0]   ccsnoopaddr
);

    localparam int IW = (CPUS > 1) ? $clog2(CPUS) : 1;

    typedef enum logic {IDLE, GRANT} state_t;
    typedef enum logic [1:0] {IFETCH, DREAD, DWRITE} gtype_t;

    state_t          state_q, state_d;
    gtype_t          gtype_q, gtype_d;
    logic [IW-1:0]   gcpu_q, gcpu_d;
    logic [IW-1:0]   rr_q, rr_d;

    logic [CPUS-1:0] dreq;
    logic            d_hit, i_hit;
    logic [IW-1:0]   d_sel, i_sel;
    logic            req_ok;
    logic            done;
    logic [31:0]     g_iaddr, g_daddr, g_dstore;

    logic unused_cc;
    assign unused_cc = ^{ccwrite, cctrans};

    assign ccwait      = '0;
    assign ccinv       = '0;
    assign ccsnoopaddr = '0;

    function automatic logic [IW-1:0] wrap(input logic [31:0] v);
        return IW'(v % 32'(CPUS));
    endfunction

    // Descending scan so the last write is the first hit from rr_q.
    always_comb begin
        dreq  = dREN | dWEN;
        d_hit = 1'b0;
        i_hit = 1'b0;
        d_sel = '0;
        i_sel = '0;
        for (int k = CPUS - 1; k >= 0; k--) begin
            if (dreq[wrap(32'(rr_q) + 32'(k))]) begin
                d_hit = 1'b1;
                d_sel = wrap(32'(rr_q) + 32'(k));
            end
            if (iREN[wrap(32'(rr_q) + 32'(k))]) begin
                i_hit = 1'b1;
                i_sel = wrap(32'(rr_q) + 32'(k));
            end
        end
    end

    always_comb begin
        g_iaddr  = iaddr[32*int'(gcpu_q) +: 32];
        g_daddr  = daddr[32*int'(gcpu_q) +: 32];
        g_dstore = dstore[32*int'(gcpu_q) +: 32];
        // A type change on the granted CPU counts as a dropped request.
        case (gtype_q)
            IFETCH:  req_ok = iREN[gcpu_q];
            DREAD:   req_ok = dREN[gcpu_q] && !dWEN[gcpu_q];
            DWRITE:  req_ok = dWEN[gcpu_q];
            default: req_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        gtype_d  = gtype_q;
        gcpu_d   = gcpu_q;
        rr_d     = rr_q;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = '1;
        dwait    = '1;
        iload    = '0;
        dload    = '0;
        done     = 1'b0;
        case (state_q)
            IDLE: begin
                if (d_hit) begin
                    state_d = GRANT;
                    gcpu_d  = d_sel;
                    gtype_d = dWEN[d_sel] ? DWRITE : DREAD;
                end else if (i_hit) begin
                    state_d = GRANT;
                    gcpu_d  = i_sel;
                    gtype_d = IFETCH;
                end
            end
            GRANT: begin
                if (!req_ok) begin
                    state_d = IDLE;
                end else begin
                    ramaddr  = (gtype_q == IFETCH) ? g_iaddr : g_daddr;
                    ramREN   = (gtype_q != DWRITE);
                    ramWEN   = (gtype_q == DWRITE);
                    ramstore = (gtype_q == DWRITE) ? g_dstore : 32'd0;
                    if (ramstate == ACCESS) begin
                        done    = 1'b1;
                        state_d = IDLE;
                        rr_d    = wrap(32'(gcpu_q) + 32'd1);
                        if (gtype_q == IFETCH) begin
                            iwait[gcpu_q] = 1'b0;
                            iload[32*int'(gcpu_q) +: 32] = ramload;
                        end else begin
                            dwait[gcpu_q] = 1'b0;
                            if (gtype_q == DREAD) begin
                                dload[32*int'(gcpu_q) +: 32] = ramload;
                            end
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            gtype_q <= IFETCH;
            gcpu_q  <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            gtype_q <= gtype_d;
            gcpu_q  <= gcpu_d;
            rr_q    <= rr_d;
        end
    end

`ifdef MEMORY_ARBITER_STATS_EN
    logic [CPUS*32-1:0] stat_q, stat_d;

    always_comb begin
        stat_d = stat_q;
        if (done && (stat_q[32*int'(gcpu_q) +: 32] != 32'hFFFF_FFFF)) begin
            stat_d[32*int'(gcpu_q) +: 32] = stat_q[32*int'(gcpu_q) +: 32] + 32'd1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stat_q <= '0;
        end else begin
            stat_q <= stat_d;
        end
    end

    assign stat_xfers = stat_q;
`else
    logic unused_done;
    assign unused_done = done;
`endif

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with two CPUs.
// Covers reset, ifetch latency, data priority, round robin, abort and async reset.
module tb_memory_arbiter;
    import memory_arbiter_pkg::*;

    localparam int CPUS = 2;

    logic              CLK = 1'b0;
    logic              nRST;
    logic [CPUS-1:0]   iREN, dREN, dWEN, ccwrite, cctrans;
    logic [CPUS*32-1:0] iaddr, daddr, dstore;
    logic [CPUS-1:0]   iwait, dwait, ccwait, ccinv;
    logic [CPUS*32-1:0] iload, dload, ccsnoopaddr;
    logic              ramREN, ramWEN;
    logic [31:0]       ramaddr, ramstore, ramload;
    ramstate_t         ramstate;
`ifdef MEMORY_ARBITER_STATS_EN
    logic [CPUS*32-1:0] stat_xfers;
`endif

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    memory_arbiter #(.CPUS(CPUS)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .ccwrite(ccwrite), .cctrans(cctrans),
        .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
`ifdef MEMORY_ARBITER_STATS_EN
        .stat_xfers(stat_xfers),
`endif
        .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr)
    );

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        iREN = '0; dREN = '0; dWEN = '0;
        ccwrite = '0; cctrans = '0;
        iaddr = '0; daddr = '0; dstore = '0;
        ramload = '0; ramstate = FREE;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        clear_inputs();
        repeat (2) @(posedge CLK);
        #1;
        nRST = 1'b1;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        clear_inputs();
        @(negedge CLK);
        tests++;
        if ({iwait, dwait} !== 4'b1111) begin
            fails++; $display("FAIL reset_waits: got %b want 1111", {iwait, dwait});
        end
        tests++;
        if ({ramREN, ramWEN, ramaddr, ramstore} !== 66'd0) begin
            fails++; $display("FAIL reset_ram: got %b %b %h %h want 0", ramREN, ramWEN, ramaddr, ramstore);
        end
        tests++;
        if ({iload, dload, ccwait, ccinv, ccsnoopaddr} !== '0) begin
            fails++; $display("FAIL reset_loads_cc: got nonzero want 0");
        end
        do_reset();
    endtask

    task automatic test_ifetch();
        do_reset();
        iREN[0] = 1'b1; iaddr[31:0] = 32'h100;
        ramstate = BUSY; ramload = 32'hDEAD_BEEF;
        @(negedge CLK);
        tests++;
        if ({ramREN, iwait[0]} !== 2'b01) begin
            fails++; $display("FAIL if_arb_cycle: got ren=%b iwait=%b want 0 1", ramREN, iwait[0]);
        end
        for (int b = 0; b < 2; b++) begin
            cyc();
            @(negedge CLK);
            tests++;
            if ({ramREN, ramaddr, iwait[0], iload[31:0]} !== {1'b1, 32'h100, 1'b1, 32'h0}) begin
                fails++; $display("FAIL if_busy%0d: got ren=%b addr=%h iwait=%b iload=%h", b, ramREN, ramaddr, iwait[0], iload[31:0]);
            end
        end
        cyc();
        ramstate = ACCESS;
        @(negedge CLK);
        tests++;
        if ({iwait[0], iload[31:0]} !== {1'b0, 32'hDEAD_BEEF}) begin
            fails++; $display("FAIL if_access: got iwait=%b iload=%h want 0 deadbeef", iwait[0], iload[31:0]);
        end
        cyc();
        iREN = '0; ramstate = FREE;
        @(negedge CLK);
        tests++;
        if ({ramREN, iwait[0], iload[31:0]} !== {2'b01, 32'h0}) begin
            fails++; $display("FAIL if_after: got ren=%b iwait=%b iload=%h", ramREN, iwait[0], iload[31:0]);
        end
    endtask

    task automatic test_data_priority();
        do_reset();
        iREN[0] = 1'b1; iaddr[31:0] = 32'h100;
        dWEN[0] = 1'b1; daddr[31:0] = 32'h200; dstore[31:0] = 32'h1234;
        ramstate = ACCESS; ramload = 32'hCAFE_F00D;
        @(negedge CLK);
        tests++;
        if ({ramWEN, iwait[0], dwait[0]} !== 3'b011) begin
            fails++; $display("FAIL pri_arb: got wen=%b iwait=%b dwait=%b", ramWEN, iwait[0], dwait[0]);
        end
        cyc();
        @(negedge CLK);
        tests++;
        if ({ramWEN, ramREN, ramaddr, ramstore} !== {2'b10, 32'h200, 32'h1234}) begin
            fails++; $display("FAIL pri_write: got wen=%b ren=%b addr=%h st=%h", ramWEN, ramREN, ramaddr, ramstore);
        end
        tests++;
        if ({dwait[0], iwait[0], dload[31:0]} !== {2'b01, 32'h0}) begin
            fails++; $display("FAIL pri_waits: got dwait=%b iwait=%b dload=%h", dwait[0], iwait[0], dload[31:0]);
        end
        cyc();
        dWEN = '0;
        @(negedge CLK);
        tests++;
        if ({ramREN, iwait[0]} !== 2'b01) begin
            fails++; $display("FAIL pri_iarb: got ren=%b iwait=%b want 0 1", ramREN, iwait[0]);
        end
        cyc();
        @(negedge CLK);
        tests++;
        if ({ramREN, ramaddr, ramstore, iwait[0], iload[31:0]} !== {1'b1, 32'h100, 32'h0, 1'b0, 32'hCAFE_F00D}) begin
            fails++; $display("FAIL pri_ifetch: got ren=%b addr=%h st=%h iwait=%b iload=%h", ramREN, ramaddr, ramstore, iwait[0], iload[31:0]);
        end
        cyc();
        iREN = '0;
    endtask

    task automatic test_round_robin();
        logic [31:0] exp_addr;
        logic [1:0]  exp_wait;
        logic [63:0] exp_load;
        do_reset();
        dREN = 2'b11;
        daddr = {32'h20, 32'h10};
        ramstate = ACCESS; ramload = 32'h55;
        for (int g = 0; g < 4; g++) begin
            exp_addr = (g % 2 == 1) ? 32'h20 : 32'h10;
            exp_wait = (g % 2 == 1) ? 2'b01 : 2'b10;
            exp_load = (g % 2 == 1) ? {32'h55, 32'h0} : {32'h0, 32'h55};
            @(negedge CLK);
            tests++;
            if (dwait !== 2'b11) begin
                fails++; $display("FAIL rr_idle%0d: got dwait=%b want 11", g, dwait);
            end
            cyc();
            @(negedge CLK);
            tests++;
            if ({dwait, ramaddr, dload} !== {exp_wait, exp_addr, exp_load}) begin
                fails++; $display("FAIL rr_grant%0d: got dwait=%b addr=%h want %b %h", g, dwait, ramaddr, exp_wait, exp_addr);
            end
            cyc();
        end
        dREN = '0;
    endtask

    task automatic test_abort();
        do_reset();
        dREN[0] = 1'b1; daddr[31:0] = 32'h40; daddr[63:32] = 32'h80;
        ramstate = BUSY;
        @(negedge CLK);
        cyc();
        @(negedge CLK);
        tests++;
        if ({ramREN, ramaddr} !== {1'b1, 32'h40}) begin
            fails++; $display("FAIL ab_grant: got ren=%b addr=%h want 1 40", ramREN, ramaddr);
        end
        cyc();
        dREN = '0;
        @(negedge CLK);
        tests++;
        if ({ramREN, dwait} !== 3'b011) begin
            fails++; $display("FAIL ab_drop: got ren=%b dwait=%b want 0 11", ramREN, dwait);
        end
        cyc();
        dREN = 2'b11; ramstate = ACCESS;
        @(negedge CLK);
        tests++;
        if ({ramREN, dwait} !== 3'b011) begin
            fails++; $display("FAIL ab_idle: got ren=%b dwait=%b want 0 11", ramREN, dwait);
        end
        cyc();
        @(negedge CLK);
        tests++;
        if ({dwait, ramaddr} !== {2'b10, 32'h40}) begin
            fails++; $display("FAIL ab_rr_kept: got dwait=%b addr=%h want 10 40", dwait, ramaddr);
        end
        cyc();
        dREN = 2'b01; ramstate = BUSY;
        @(negedge CLK);
        cyc();
        @(negedge CLK);
        tests++;
        if (ramREN !== 1'b1) begin
            fails++; $display("FAIL ab_type_grant: got ren=%b want 1", ramREN);
        end
        cyc();
        dWEN[0] = 1'b1;
        @(negedge CLK);
        tests++;
        if ({ramREN, ramWEN, dwait} !== 4'b0011) begin
            fails++; $display("FAIL ab_type_change: got ren=%b wen=%b dwait=%b want 0 0 11", ramREN, ramWEN, dwait);
        end
        cyc();
        dREN = '0; dWEN = '0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        dREN[0] = 1'b1; daddr[31:0] = 32'h40; ramstate = ACCESS;
        @(negedge CLK);
        cyc();
        @(negedge CLK);
        cyc();
        dREN = '0;
        dWEN[1] = 1'b1; daddr[63:32] = 32'h300; dstore[63:32] = 32'hABCD;
        ramstate = BUSY;
        @(negedge CLK);
        cyc();
        @(negedge CLK);
        tests++;
        if ({ramWEN, ramaddr, ramstore} !== {1'b1, 32'h300, 32'hABCD}) begin
            fails++; $display("FAIL rm_write: got wen=%b addr=%h st=%h", ramWEN, ramaddr, ramstore);
        end
        #2;
        nRST = 1'b0;
        #1;
        tests++;
        if ({ramWEN, ramaddr, ramstore, iwait, dwait} !== {1'b0, 64'h0, 4'b1111}) begin
            fails++; $display("FAIL rm_async: got wen=%b addr=%h st=%h iw=%b dw=%b", ramWEN, ramaddr, ramstore, iwait, dwait);
        end
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        dWEN = 2'b11; daddr[31:0] = 32'h500; ramstate = ACCESS;
        @(negedge CLK);
        cyc();
        @(negedge CLK);
        tests++;
        if ({ramWEN, dwait, ramaddr} !== {1'b1, 2'b10, 32'h500}) begin
            fails++; $display("FAIL rm_rr_zero: got wen=%b dwait=%b addr=%h want 1 10 500", ramWEN, dwait, ramaddr);
        end
        cyc();
        dWEN = '0;
    endtask

`ifdef MEMORY_ARBITER_STATS_EN
    task automatic test_stats();
        do_reset();
        dREN[0] = 1'b1; ramstate = ACCESS;
        for (int n = 0; n < 3; n++) begin
            @(negedge CLK);
            cyc();
            @(negedge CLK);
            cyc();
        end
        dREN = '0;
        @(negedge CLK);
        tests++;
        if (stat_xfers !== {32'd0, 32'd3}) begin
            fails++; $display("FAIL stats_count: got %h want 0000000000000003", stat_xfers);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        clear_inputs();
        nRST = 1'b1;
        test_reset();
        test_ifetch();
        test_data_priority();
        test_round_robin();
        test_abort();
        test_reset_mid();
`ifdef MEMORY_ARBITER_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
